// File: rtl/mvp_acc.sv
// Bit-plane shift-accumulator: folds MSB-first partial-sum planes into n-lane results
// and emits each finished vector over a valid/ready handshake. Optional MVP_ACC_SAT_EN adds lane saturation and a sticky sat_o flag.
module mvp_acc #(
  parameter int n    = 64,
  parameter int ACCW = 32,
  parameter int PMAX = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic                              in_first_i,
  input  logic                              in_last_i,
  input  logic                              in_neg_i,
  input  logic [n*($clog2(n)+2)-1:0]        s_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [n*ACCW-1:0]                 out_data_o,
  output logic [$clog2(PMAX+1)-1:0]         out_planes_o,
`ifdef MVP_ACC_SAT_EN
  output logic                              sat_o,
`endif
  output logic                              err_o
);

  localparam int A  = $clog2(n);
  localparam int LW = A + 2;
  localparam int CW = $clog2(PMAX + 1);
`ifdef MVP_ACC_SAT_EN
  localparam int RW = ACCW + 1;
`else
  localparam int RW = ACCW;
`endif

  localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ACCW-1:0]     acc_q [n];
  logic [ACCW-1:0]     acc_d [n];
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [n*ACCW-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]       out_planes_q, out_planes_d;
  logic                err_q, err_d;
  logic                accept_s;
  logic                starting_s;
`ifdef MVP_ACC_SAT_EN
  logic                sat_q, sat_d;
  logic [n-1:0]        clip_s;
`endif

  // One lane step; in saturating builds the top bit of the result flags a clip.
  function automatic logic [RW-1:0] lane_next(input logic [ACCW-1:0] acc,
                                              input logic [LW-1:0]   s,
                                              input logic            neg,
                                              input logic            start);
    logic [ACCW-1:0] t;
    logic [ACCW-1:0] base;
`ifdef MVP_ACC_SAT_EN
    logic [ACCW:0]   sum;
    logic            clip;
    logic [ACCW-1:0] value;
`endif
    t = {{(ACCW-LW){s[LW-1]}}, s};
    if (neg) begin
      t = {ACCW{1'b0}} - t;
    end else begin
      t = t;
    end
`ifdef MVP_ACC_SAT_EN
    clip = 1'b0;
    if (start) begin
      base = {ACCW{1'b0}};
    end else if (acc[ACCW-1] != acc[ACCW-2]) begin
      base = acc[ACCW-1] ? ACC_MIN : ACC_MAX;
      clip = 1'b1;
    end else begin
      base = {acc[ACCW-2:0], 1'b0};
    end
    sum = {base[ACCW-1], base} + {t[ACCW-1], t};
    if (sum[ACCW] != sum[ACCW-1]) begin
      value = sum[ACCW] ? ACC_MIN : ACC_MAX;
      clip  = 1'b1;
    end else begin
      value = sum[ACCW-1:0];
    end
    return {clip, value};
`else
    base = start ? {ACCW{1'b0}} : {acc[ACCW-2:0], 1'b0};
    return base + t;
`endif
  endfunction

  assign in_ready_o = !(out_valid_q && !out_ready_i);
  assign accept_s   = in_valid_i && in_ready_o;
  // A beat in IDLE always starts a vector, even when in_first is missing.
  assign starting_s = (state_q == IDLE) || in_first_i;

  // Next-state: FSM, plane counter, accumulators and output holding registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    acc_d        = acc_q;
    out_data_d   = out_data_q;
    out_planes_d = out_planes_q;
    out_valid_d  = out_valid_q && !out_ready_i;
`ifdef MVP_ACC_SAT_EN
    sat_d        = sat_q;
    clip_s       = {n{1'b0}};
`endif
    if (accept_s) begin
      if ((state_q == IDLE) != in_first_i) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      if (starting_s) begin
        cnt_d = CW'(1);
      end else if (cnt_q >= CW'(PMAX)) begin
        cnt_d = CW'(PMAX);
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      for (int i = 0; i < n; i++) begin
`ifdef MVP_ACC_SAT_EN
        {clip_s[i], acc_d[i]} = lane_next(acc_q[i], s_i[i*LW +: LW], in_neg_i, starting_s);
`else
        acc_d[i] = lane_next(acc_q[i], s_i[i*LW +: LW], in_neg_i, starting_s);
`endif
      end
`ifdef MVP_ACC_SAT_EN
      sat_d = sat_q || (|clip_s);
`endif
      state_d = in_last_i ? IDLE : ACC;
      if (in_last_i) begin
        out_valid_d  = 1'b1;
        out_planes_d = cnt_d;
        for (int i = 0; i < n; i++) begin
          out_data_d[i*ACCW +: ACCW] = acc_d[i];
        end
      end else begin
        out_planes_d = out_planes_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= {CW{1'b0}};
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {(n*ACCW){1'b0}};
      out_planes_q <= {CW{1'b0}};
      for (int i = 0; i < n; i++) begin
        acc_q[i] <= {ACCW{1'b0}};
      end
`ifdef MVP_ACC_SAT_EN
      sat_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_planes_q <= out_planes_d;
      acc_q        <= acc_d;
`ifdef MVP_ACC_SAT_EN
      sat_q        <= sat_d;
`endif
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_planes_o = out_planes_q;
  assign err_o        = err_q;
`ifdef MVP_ACC_SAT_EN
  assign sat_o        = sat_q;
`endif

endmodule
